// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package ex_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_type;

  typedef struct packed {
    logic          muldiv;
    muldiv_op_type op;
  } control_type;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  function automatic logic is_div_op(input muldiv_op_type op);
    return op[2];
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
interface ex_muldiv_unit_if;
  import ex_muldiv_unit_pkg::*;

  logic          start;
  logic          flush;
  muldiv_op_type op;
  logic [31:0]   operand_a;
  logic [31:0]   operand_b;
  logic          busy;
  logic          result_valid;
  logic [31:0]   result;

  modport master (
    output start, flush, op, operand_a, operand_b,
    input  busy, result_valid, result
  );

  modport slave (
    input  start, flush, op, operand_a, operand_b,
    output busy, result_valid, result
  );
endinterface

// File: rtl/ex_muldiv_unit_div_core.sv
// Restoring division on unsigned magnitudes, one quotient bit per cycle.
// quotient/remainder present the post-step values so the caller can register them on done.
module ex_muldiv_unit_div_core #(
  parameter int DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        kill,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);
  localparam int CW = $clog2(DIV_STEPS);

  logic [31:0]   rem_r, quo_r, div_r;
  logic [CW-1:0] count;
  logic          active;
  logic [32:0]   shifted, diff;
  logic          fits;

  assign shifted   = {rem_r, quo_r[31]};
  assign diff      = shifted - {1'b0, div_r};
  assign fits      = ~diff[32];
  assign remainder = fits ? diff[31:0] : shifted[31:0];
  assign quotient  = {quo_r[30:0], fits};
  assign done      = active && (count == CW'(DIV_STEPS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_r  <= '0;
      quo_r  <= '0;
      div_r  <= '0;
      count  <= '0;
      active <= 1'b0;
    end else if (kill) begin
      count  <= '0;
      active <= 1'b0;
    end else if (load) begin
      rem_r  <= '0;
      quo_r  <= dividend;
      div_r  <= divisor;
      count  <= '0;
      active <= 1'b1;
    end else if (active) begin
      rem_r <= remainder;
      quo_r <= quotient;
      if (done) begin
        count  <= '0;
        active <= 1'b0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit feeding the EX/MEM ALU-result path.
// state | meaning
// IDLE  | waiting for start; latches op and operands
// MUL   | single-cycle 64-bit product, result registered
// DIV   | DIV_STEPS restoring iterations in div_core
// DONE  | result_valid high for one cycle
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input logic              clk,
  input logic              reset_n,
  ex_muldiv_unit_if.slave  bus
);
  muldiv_state_type state;
  muldiv_op_type    op_q;
  logic [31:0]      a_q, b_q, result_q;
  logic             result_valid_q, neg_q, neg_r, rem_sel;

  logic        accept, div_req, signed_req, rem_req, div_zero, div_ovf, fast;
  logic [31:0] fast_result, mag_a, mag_b;

  assign accept      = (state == IDLE) && bus.start && !bus.flush;
  assign div_req     = is_div_op(bus.op);
  assign signed_req  = (bus.op == OP_DIV) || (bus.op == OP_REM);
  assign rem_req     = (bus.op == OP_REM) || (bus.op == OP_REMU);
  assign div_zero    = (bus.operand_b == 32'd0);
  assign div_ovf     = signed_req && (bus.operand_a == INT_MIN) && (bus.operand_b == 32'hFFFF_FFFF);
  assign fast        = div_req && (div_zero || div_ovf);
  assign fast_result = div_zero ? (rem_req ? bus.operand_a : DIV_BY_ZERO_Q)
                                : (rem_req ? 32'd0 : INT_MIN);
  assign mag_a = (signed_req && bus.operand_a[31]) ? (~bus.operand_a + 32'd1) : bus.operand_a;
  assign mag_b = (signed_req && bus.operand_b[31]) ? (~bus.operand_b + 32'd1) : bus.operand_b;

  // Low 64 bits of the 33x33 extended product are all that any op selects.
  logic        a_sign, b_sign;
  logic [63:0] a_wide, b_wide, product;

  assign a_sign  = a_q[31] && ((op_q == OP_MULH) || (op_q == OP_MULHSU));
  assign b_sign  = b_q[31] && (op_q == OP_MULH);
  assign a_wide  = {{32{a_sign}}, a_q};
  assign b_wide  = {{32{b_sign}}, b_q};
  assign product = a_wide * b_wide;

  logic        div_load, div_done;
  logic [31:0] div_quo, div_rem, q_fix, r_fix;

  assign div_load = accept && div_req && !fast;

  ex_muldiv_unit_div_core #(.DIV_STEPS(DIV_STEPS)) u_div_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (div_load),
    .kill      (bus.flush),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  assign q_fix = neg_q ? (~div_quo + 32'd1) : div_quo;
  assign r_fix = neg_r ? (~div_rem + 32'd1) : div_rem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      op_q           <= OP_MUL;
      a_q            <= '0;
      b_q            <= '0;
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
      rem_sel        <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if (bus.flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            op_q    <= bus.op;
            a_q     <= bus.operand_a;
            b_q     <= bus.operand_b;
            neg_q   <= signed_req && (bus.operand_a[31] ^ bus.operand_b[31]);
            neg_r   <= signed_req && bus.operand_a[31];
            rem_sel <= rem_req;
            if (!div_req) begin
              state <= MUL;
            end else if (fast) begin
              state          <= DONE;
              result_q       <= fast_result;
              result_valid_q <= 1'b1;
            end else begin
              state <= DIV;
            end
          end
          MUL: begin
            result_q       <= (op_q == OP_MUL) ? product[31:0] : product[63:32];
            result_valid_q <= 1'b1;
            state          <= DONE;
          end
          DIV: if (div_done) begin
            result_q       <= rem_sel ? r_fix : q_fix;
            result_valid_q <= 1'b1;
            state          <= DONE;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy         = reset_n && (accept || (state == MUL) || (state == DIV));
  assign bus.result_valid = result_valid_q;
  assign bus.result       = result_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed and randomised checks of ex_muldiv_unit with an expected-result queue.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = 32'd0;

  ex_muldiv_unit_if bus();

  ex_muldiv_unit #(.DIV_STEPS(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model(input muldiv_op_type o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (o)
      OP_MUL:    begin p = sa * sb; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      OP_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      OP_REM:    begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input muldiv_op_type o, input logic [31:0] a, input logic [31:0] b);
    if (!o[2]) return 2;
    if (b == 0) return 1;
    if ((o == OP_DIV || o == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Start in the current cycle, then scramble the ports to prove operands were latched.
  task automatic run_op(input string tag, input muldiv_op_type o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expv, input int lat);
    int got;
    logic [31:0] popped;
    bus.op = o; bus.operand_a = a; bus.operand_b = b; bus.start = 1'b1;
    #1;
    check({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
    exp_q.push_back(expv);
    tick();
    bus.start = 1'b0;
    bus.op = muldiv_op_type'($urandom_range(0, 7));
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    got = 0;
    for (int n = 1; n <= lat + 3; n++) begin
      #1;
      if (bus.result_valid) begin
        got = n;
        break;
      end
      check({tag, "_busy_wait"}, 32'(bus.busy), 32'd1);
      tick();
    end
    check({tag, "_latency"}, 32'(got), 32'(lat));
    popped = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    if (got != 0) begin
      check({tag, "_result"}, bus.result, popped);
      check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    end
    last_exp = popped;
    tick();
  endtask

  task automatic run_model(input string tag, input muldiv_op_type o, input logic [31:0] a, input logic [31:0] b);
    run_op(tag, o, a, b, model(o, a, b), latency(o, a, b));
  endtask

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = OP_MUL;
    bus.operand_a = 32'd0; bus.operand_b = 32'd0;
    reset_n = 1'b0;
    tick(); tick();
    bus.start = 1'b1;
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_valid", 32'(bus.result_valid), 32'd0);
    check("reset_result", bus.result, 32'd0);
    bus.start = 1'b0;
    reset_n = 1'b1;
    tick();

    run_op("mul_7x-3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
    run_op("mulhu_ff", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run_op("mulh_ff", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2);
    run_op("mulhsu_ff", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    run_op("div_neg20_3", OP_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);
    run_op("rem_neg20_3", OP_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    run_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_by0", OP_REM, 32'd100, 32'd0, 32'd100, 1);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    for (int i = 0; i < 8; i++) begin
      muldiv_op_type o;
      logic [31:0] a, b;
      o = muldiv_op_type'(i);
      a = $urandom;
      b = (i == 6) ? 32'd0 : $urandom;
      run_model($sformatf("rand_op%0d", i), o, a, b);
    end

    // Flush an in-flight divide at t+10; restart a multiply at t+11.
    bus.op = OP_DIVU; bus.operand_a = 32'd5000; bus.operand_b = 32'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int n = 1; n < 10; n++) begin
      #1;
      check("flush_no_valid", 32'(bus.result_valid), 32'd0);
      tick();
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    check("flush_valid", 32'(bus.result_valid), 32'd0);
    check("flush_result_held", bus.result, last_exp);
    run_op("mul_after_flush", OP_MUL, 32'd3, 32'd4, 32'd12, 2);

    // start and flush together: nothing executes.
    bus.op = OP_MUL; bus.operand_a = 32'd9; bus.operand_b = 32'd9;
    bus.start = 1'b1; bus.flush = 1'b1;
    #1;
    check("start_flush_busy", 32'(bus.busy), 32'd0);
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      check("start_flush_idle_busy", 32'(bus.busy), 32'd0);
      check("start_flush_no_valid", 32'(bus.result_valid), 32'd0);
      tick();
    end

    // Reset asserted at t+5 of a divide.
    bus.op = OP_DIV; bus.operand_a = 32'd1000; bus.operand_b = 32'd7; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    bus.start = 1'b1;
    reset_n = 1'b0;
    #1;
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_valid", 32'(bus.result_valid), 32'd0);
    check("midreset_result", bus.result, 32'd0);
    bus.start = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    run_op("mul_after_reset", OP_MUL, 32'd9, 32'd9, 32'd81, 2);

    // start held high through MUL and DONE is re-accepted only in IDLE.
    bus.op = OP_MUL; bus.operand_a = 32'd5; bus.operand_b = 32'd6; bus.start = 1'b1;
    exp_q.push_back(32'd30);
    tick();
    bus.operand_a = 32'd2; bus.operand_b = 32'd3;
    #1;
    check("held_t1_valid", 32'(bus.result_valid), 32'd0);
    check("held_t1_busy", 32'(bus.busy), 32'd1);
    tick();
    check("held_t2_valid", 32'(bus.result_valid), 32'd1);
    check("held_t2_result", bus.result, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF);
    check("held_t2_busy", 32'(bus.busy), 32'd0);
    tick();
    check("held_t3_valid", 32'(bus.result_valid), 32'd0);
    check("held_t3_busy", 32'(bus.busy), 32'd1);
    exp_q.push_back(32'd6);
    tick();
    bus.start = 1'b0;
    #1;
    check("held_t4_valid", 32'(bus.result_valid), 32'd0);
    tick();
    check("held_t5_valid", 32'(bus.result_valid), 32'd1);
    check("held_t5_result", bus.result, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF);
    tick();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
